// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit that owns the HI and LO registers.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   mult, multu, div, divu      start strobes (one-hot or all zero)
//   mthi, mtlo                  write HI/LO from a (idle only, no start pending)
//   mfhi, mflo                  select HI/LO onto rdata
//   a, b                        rs / rt operands
//   rdata                       HI if mfhi, LO if mflo, else 0 (combinational)
//   hi, lo                      current HI/LO registers
//   busy                        operation in flight (stall request)
//   done                        one-cycle pulse after HI/LO update from an operation
//
// Build option: define MULDIV_FAST_MULT_EN to use a single-cycle multiplier
// for mult/multu (HI/LO written at the start edge, busy never asserted).
//
// state  | meaning
// IDLE   | waiting for a start strobe; mthi/mtlo accepted
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle

module muldiv_hilo #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [5:0] LAST   = 6'(ITER - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV) magnitude
    logic [31:0] a_q, a_d;         // original rs, needed for divide-by-zero HI
    logic        psign_q, psign_d; // product / quotient sign
    logic        rsign_q, rsign_d; // remainder sign
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        start, is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, prod_fix;
    logic [32:0] div_top;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [31:0] quo_fix, rem_fix;

    assign start     = mult | multu | div | divu;
    assign is_signed = mult | div;
    assign a_mag     = (is_signed && a[31]) ? -a : a;
    assign b_mag     = (is_signed && b[31]) ? -b : b;

    // acc = {partial product, remaining multiplier bits}; carry-out is kept
    // by shifting the 33-bit sum back into the top of the accumulator.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};
    assign prod_fix = psign_q ? -mul_next : mul_next;

    // acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    // The shifted remainder needs 33 bits; the difference always fits in 32.
    assign div_top  = acc_q[63:31];
    assign div_ge   = div_top >= {1'b0, opnd_q};
    assign div_rem  = div_ge ? (div_top[31:0] - opnd_q) : div_top[31:0];
    assign div_next = {div_rem, acc_q[30:0], div_ge};
    assign quo_fix  = psign_q ? -div_next[31:0] : div_next[31:0];
    assign rem_fix  = rsign_q ? -div_next[63:32] : div_next[63:32];

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_ax, fast_bx, fast_prod;
    // Sign-extending for mult makes the low 64 bits of the product the
    // correct two's complement result.
    assign fast_ax   = {{32{mult & a[31]}}, a};
    assign fast_bx   = {{32{mult & b[31]}}, b};
    assign fast_prod = fast_ax * fast_bx;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        a_d     = a_q;
        psign_d = psign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MULT_EN
                    if (mult || multu) begin
                        hi_d   = fast_prod[63:32];
                        lo_d   = fast_prod[31:0];
                        done_d = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        acc_d   = {32'd0, a_mag};
                        opnd_d  = b_mag;
                        a_d     = a;
                        psign_d = is_signed & (a[31] ^ b[31]);
                        rsign_d = is_signed & a[31];
                        cnt_d   = 6'd0;
                    end
`else
                    state_d = (mult || multu) ? S_MUL : S_DIV;
                    acc_d   = (mult || multu) ? {32'd0, b_mag} : {32'd0, a_mag};
                    opnd_d  = (mult || multu) ? a_mag : b_mag;
                    a_d     = a;
                    psign_d = is_signed & (a[31] ^ b[31]);
                    rsign_d = is_signed & a[31];
                    cnt_d   = 6'd0;
`endif
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    hi_d    = prod_fix[63:32];
                    lo_d    = prod_fix[31:0];
                    done_d  = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    if (opnd_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    done_d  = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            a_q     <= 32'd0;
            psign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            psign_q <= psign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign rdata = mfhi ? hi_q : (mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mult, multu, div, divu, mthi, mtlo, mfhi, mflo;
    logic [31:0] a, b;
    logic [31:0] rdata, hi, lo;
    logic        busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];     // expected {hi, lo} per issued operation
    int          lat_q[$];  // expected busy cycles per issued operation

    muldiv_hilo #(.ITER(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
        .a(a), .b(b), .rdata(rdata), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input int op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            OP_MULT:  return 64'(sx * sy);
            OP_MULTU: return {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (op == OP_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                end else begin
                    q = longint'({32'd0, x}) / longint'({32'd0, y});
                    r = longint'({32'd0, x}) % longint'({32'd0, y});
                end
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Called at a falling edge; the strobe is taken at the next rising edge.
    task automatic issue(input int op, input logic [31:0] x, input logic [31:0] y);
        a = x; b = y;
        mult = (op == OP_MULT); multu = (op == OP_MULTU);
        div = (op == OP_DIV);   divu = (op == OP_DIVU);
        sb.push_back(model(op, x, y));
        lat_q.push_back((FAST && op <= OP_MULTU) ? 0 : 32);
        @(negedge clk);
        mult = 0; multu = 0; div = 0; divu = 0;
    endtask

    // Counts busy cycles starting at the current falling edge, then checks
    // the done pulse and HI/LO against the oldest scoreboard entry.
    task automatic wait_op(input string tag, input int already);
        int n;
        int exp_lat;
        logic [63:0] e;
        n = already;
        exp_lat = lat_q.pop_front();
        e = sb.pop_front();
        if (exp_lat > 0) check({tag, "_done_low"}, 32'(done), 32'd0);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_lat));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hi"}, hi, e[63:32]);
        check({tag, "_lo"}, lo, e[31:0]);
    endtask

    initial begin
        logic [63:0] dropped;
        rst_n = 0;
        mult = 0; multu = 0; div = 0; divu = 0;
        mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
        a = 0; b = 0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_op("multu_max", 0);
        // back-to-back: issued in the first idle cycle
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_op("mult_neg", 0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_op("div_neg", 0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_op("div_ovf", 0);
        issue(OP_DIVU, 32'h1234_5678, 32'd0);
        wait_op("divu_zero", 0);
        issue(OP_DIV, 32'hFFFF_FF00, 32'd0);
        wait_op("div_zero", 0);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_op("divu_basic", 0);

        mflo = 1; #1;
        check("mflo_rdata", rdata, 32'd14);
        mflo = 0;
        @(negedge clk);

        mthi = 1; a = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 0; mfhi = 1; #1;
        check("mthi_rdata", rdata, 32'hA5A5_A5A5);
        check("mthi_no_done", 32'(done), 32'd0);
        mfhi = 0;
        @(negedge clk);

        // mtlo during a busy divu must be ignored; also mfhi shows old HI
        issue(OP_DIVU, 32'd1000, 32'd9);
        mtlo = 1; a = 32'hDEAD_BEEF; mfhi = 1; #1;
        check("busy_mfhi_old", rdata, 32'hA5A5_A5A5);
        @(negedge clk);
        mtlo = 0; mfhi = 0;
        wait_op("divu_mtlo", 1);

        // reset mid-operation
        issue(OP_MULTU, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        rst_n = 0; #1;
        dropped = sb.pop_front();
        void'(lat_q.pop_front());
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        issue(OP_MULTU, 32'd7, 32'd9);
        wait_op("multu_restart", 0);
        check("restart_model", lo, dropped[31:0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
